// File: rtl/fb_console_pkg.sv
// Shared types and constants for the framebuffer text-console sequencer.
// Optional build macro used by the top: FB_CONSOLE_AUTOWRAP_EN.
package fb_console_pkg;

    localparam int ADDR_W   = 12;
    localparam int DEF_COLS = 98;
    localparam int DEF_ROWS = 36;

    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_FF = 8'h0C;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        CLEAR,
        SCROLL_RD,
        SCROLL_WAIT,
        SCROLL_WR,
        FILL
    } state_t;

endpackage

// File: rtl/fb_console_ctrl_addr_calc.sv
// Registered cursor-to-cell address: addr = row*COLS + col, one cycle behind the cursor.
module fb_addr_calc
    import fb_console_pkg::*;
#(
    parameter int COLS = DEF_COLS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        row,
    input  logic [6:0]        col,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else begin
            addr <= ADDR_W'(row) * COLS_A + ADDR_W'(col);
        end
    end

endmodule

// File: rtl/fb_console_ctrl.sv
// Text-console sequencer driving framebuffer port B: glyph print, LF/CR/BS/FF, clear and scroll.
// Build macro FB_CONSOLE_AUTOWRAP_EN: a printable byte in the last column wraps to the next line.
module fb_console_ctrl
    import fb_console_pkg::*;
#(
    parameter int         COLS       = DEF_COLS,
    parameter int         ROWS       = DEF_ROWS,
    parameter logic [7:0] FILL_CHAR  = 8'h20,
    parameter int         RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        busy,
    output logic [6:0]  cur_col,
    output logic [5:0]  cur_row,
    output logic [11:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        fb_we,
    output logic [11:0] fb_addr_rd,
    output logic        fb_rd_en,
    input  logic [7:0]  fb_data_rd
);

    localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL   = ADDR_W'(COLS*ROWS - 1);
    localparam logic [ADDR_W-1:0] SCROLL_LAST = ADDR_W'((ROWS-1)*COLS - 1);
    localparam logic [ADDR_W-1:0] FILL_FIRST  = ADDR_W'((ROWS-1)*COLS);
    localparam logic [6:0]        LAST_COL    = 7'(COLS - 1);
    localparam logic [5:0]        LAST_ROW    = 6'(ROWS - 1);
    localparam logic [1:0]        WAIT_INIT   = 2'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] cell_addr;
    logic [1:0]        wait_cnt;
    logic [7:0]        data_q;
    logic              pass;
    logic              wrap_scroll;

    fb_addr_calc #(.COLS(COLS)) u_addr_calc (
        .clk  (clk),
        .rst  (rst),
        .row  (cur_row),
        .col  (cur_col),
        .addr (cell_addr)
    );

    // Scroll copy writes forward the read port data in the same cycle, keeping a cell at 1+RD_LATENCY cycles.
    assign fb_data = pass ? fb_data_rd : data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            char_ready  <= 1'b0;
            busy        <= 1'b0;
            cur_col     <= '0;
            cur_row     <= '0;
            fb_addr     <= '0;
            fb_we       <= 1'b0;
            fb_addr_rd  <= '0;
            fb_rd_en    <= 1'b0;
            idx         <= '0;
            wait_cnt    <= '0;
            data_q      <= '0;
            pass        <= 1'b0;
            wrap_scroll <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!char_ready) begin
                        char_ready <= 1'b1;
                    end else if (char_valid) begin
                        char_ready <= 1'b0;
                        state      <= PUT;
                        case (char_data)
                            CC_LF: begin
                                if (cur_row == LAST_ROW) begin
                                    state      <= SCROLL_RD;
                                    busy       <= 1'b1;
                                    fb_rd_en   <= 1'b1;
                                    fb_addr_rd <= COLS_A;
                                    idx        <= '0;
                                end else begin
                                    cur_row <= cur_row + 6'd1;
                                end
                            end
                            CC_CR: cur_col <= '0;
                            CC_BS: begin
                                if (cur_col != 7'd0) begin
                                    cur_col <= cur_col - 7'd1;
                                    fb_we   <= 1'b1;
                                    fb_addr <= cell_addr - 12'd1;
                                    data_q  <= FILL_CHAR;
                                end
                            end
                            CC_FF: begin
                                state   <= CLEAR;
                                busy    <= 1'b1;
                                cur_col <= '0;
                                cur_row <= '0;
                                fb_we   <= 1'b1;
                                fb_addr <= '0;
                                data_q  <= FILL_CHAR;
                            end
                            default: begin
                                // cell_addr is stable here: the cursor has not moved for at least one cycle
                                fb_we   <= 1'b1;
                                fb_addr <= cell_addr;
                                data_q  <= char_data;
                                if (cur_col != LAST_COL) begin
                                    cur_col <= cur_col + 7'd1;
                                end
`ifdef FB_CONSOLE_AUTOWRAP_EN
                                else begin
                                    cur_col <= '0;
                                    if (cur_row == LAST_ROW) begin
                                        wrap_scroll <= 1'b1;
                                    end else begin
                                        cur_row <= cur_row + 6'd1;
                                    end
                                end
`endif
                            end
                        endcase
                    end
                end
                PUT: begin
                    fb_we <= 1'b0;
                    if (wrap_scroll) begin
                        wrap_scroll <= 1'b0;
                        state       <= SCROLL_RD;
                        busy        <= 1'b1;
                        fb_rd_en    <= 1'b1;
                        fb_addr_rd  <= COLS_A;
                        idx         <= '0;
                    end else begin
                        state      <= IDLE;
                        char_ready <= 1'b1;
                    end
                end
                CLEAR, FILL: begin
                    if (fb_addr == LAST_CELL) begin
                        fb_we      <= 1'b0;
                        busy       <= 1'b0;
                        char_ready <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        fb_addr <= fb_addr + 12'd1;
                    end
                end
                SCROLL_RD: begin
                    fb_rd_en <= 1'b0;
                    if (RD_LATENCY > 1) begin
                        state    <= SCROLL_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        state   <= SCROLL_WR;
                        fb_we   <= 1'b1;
                        fb_addr <= idx;
                        pass    <= 1'b1;
                    end
                end
                SCROLL_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state   <= SCROLL_WR;
                        fb_we   <= 1'b1;
                        fb_addr <= idx;
                        pass    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                SCROLL_WR: begin
                    fb_we  <= 1'b0;
                    pass   <= 1'b0;
                    data_q <= fb_data_rd;
                    if (idx == SCROLL_LAST) begin
                        state   <= FILL;
                        fb_we   <= 1'b1;
                        fb_addr <= FILL_FIRST;
                        data_q  <= FILL_CHAR;
                    end else begin
                        idx        <= idx + 12'd1;
                        state      <= SCROLL_RD;
                        fb_rd_en   <= 1'b1;
                        fb_addr_rd <= idx + 12'd1 + COLS_A;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_console_ctrl.sv
// Scoreboard bench for fb_console_ctrl: a console model predicts every port-B write and read.
// Model follows FB_CONSOLE_AUTOWRAP_EN when the build defines it.
module tb_fb_console_ctrl;

    localparam int COLS  = 98;
    localparam int ROWS  = 36;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        busy;
    logic [6:0]  cur_col;
    logic [5:0]  cur_row;
    logic [11:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic [11:0] fb_addr_rd;
    logic        fb_rd_en;
    logic [7:0]  fb_data_rd = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem    [0:4095];
    logic [7:0]  shadow [0:4095];
    logic [19:0] sb_wr  [$];
    logic [11:0] sb_rd  [$];
    int          mcol = 0;
    int          mrow = 0;

    fb_console_ctrl #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .FILL_CHAR  (8'h20),
        .RD_LATENCY (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .busy       (busy),
        .cur_col    (cur_col),
        .cur_row    (cur_row),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .fb_addr_rd (fb_addr_rd),
        .fb_rd_en   (fb_rd_en),
        .fb_data_rd (fb_data_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Framebuffer port B with one cycle read latency
    always @(posedge clk) begin
        if (fb_we) mem[fb_addr] <= fb_data;
        if (fb_rd_en) fb_data_rd <= mem[fb_addr_rd];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fb_we || fb_rd_en) check("we_rd_excl", 32'(fb_we & fb_rd_en), 32'd0);
            if (busy) check("rdy_busy", 32'(char_ready), 32'd0);
            if (fb_we) begin
                check("wr_pending", 32'(sb_wr.size() > 0), 32'd1);
                if (sb_wr.size() > 0) begin
                    logic [19:0] e;
                    e = sb_wr.pop_front();
                    check("wr_addr", 32'(fb_addr), 32'(e[19:8]));
                    check("wr_data", 32'(fb_data), 32'(e[7:0]));
                end
            end
            if (fb_rd_en) begin
                check("rd_pending", 32'(sb_rd.size() > 0), 32'd1);
                if (sb_rd.size() > 0) begin
                    logic [11:0] r;
                    r = sb_rd.pop_front();
                    check("rd_addr", 32'(fb_addr_rd), 32'(r));
                end
            end
        end
    end

    task automatic exp_wr(input int a, input logic [7:0] d);
        sb_wr.push_back({12'(a), d});
        shadow[a] = d;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < CELLS - COLS; i++) begin
            sb_rd.push_back(12'(i + COLS));
            exp_wr(i, shadow[i + COLS]);
        end
        for (int i = CELLS - COLS; i < CELLS; i++) exp_wr(i, 8'h20);
    endtask

    task automatic model_char(input logic [7:0] b);
        case (b)
            8'h0A: if (mrow < ROWS - 1) mrow++; else model_scroll();
            8'h0D: mcol = 0;
            8'h08: if (mcol > 0) begin mcol--; exp_wr(mrow * COLS + mcol, 8'h20); end
            8'h0C: begin
                for (int i = 0; i < CELLS; i++) exp_wr(i, 8'h20);
                mcol = 0;
                mrow = 0;
            end
            default: begin
                exp_wr(mrow * COLS + mcol, b);
                if (mcol < COLS - 1) mcol++;
`ifdef FB_CONSOLE_AUTOWRAP_EN
                else begin
                    mcol = 0;
                    if (mrow < ROWS - 1) mrow++; else model_scroll();
                end
`endif
            end
        endcase
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = b;
        while (!char_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 32'(n < 20000), 32'd1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        model_char(b);
        send(b);
    endtask

    task automatic wait_idle(output int low, output int nb);
        int n = 0;
        low = 0;
        nb  = 0;
        @(negedge clk);
        while (!char_ready && n < 20000) begin
            low++;
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 20000), 32'd1);
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_col"}, 32'(cur_col), 32'(mcol));
        check({tag, "_row"}, 32'(cur_row), 32'(mrow));
        check({tag, "_drain"}, 32'(sb_wr.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    32'(fb_we),      32'd0);
        check({tag, "_rd"},    32'(fb_rd_en),   32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_rdy"},   32'(char_ready), 32'd0);
        check({tag, "_col"},   32'(cur_col),    32'd0);
        check({tag, "_row"},   32'(cur_row),    32'd0);
        check({tag, "_addr"},  32'(fb_addr),    32'd0);
        check({tag, "_raddr"}, 32'(fb_addr_rd), 32'd0);
        check({tag, "_data"},  32'(fb_data),    32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        int nb;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check("rdy_first_cycle", 32'(char_ready), 32'd0);
        @(negedge clk);
        check("rdy_after", 32'(char_ready), 32'd1);

        put(8'h41);
        wait_idle(low, nb);
        check("put_rdy_low", 32'(low), 32'd1);
        check_cursor("put_a");

        put(8'h0C);
        wait_idle(low, nb);
        check("clr_busy", 32'(nb), 32'(CELLS));
        check("clr_rd_drain", 32'(sb_rd.size()), 32'd0);
        check_cursor("clear");

        put(8'h0A);
        for (int k = 0; k < 6; k++) put(8'h20);
        put(8'h08);
        put(8'h42);
        wait_idle(low, nb);
        check_cursor("b_at_5_1");

        for (int k = 0; k < 34; k++) put(8'h0A);
        wait_idle(low, nb);
        check_cursor("row35");

        put(8'h0A);
        wait_idle(low, nb);
        check("scroll_busy", 32'(nb), 32'((CELLS - COLS) * 2 + COLS));
        check_cursor("scroll");

        put(8'h0D);
        for (int k = 0; k < COLS - 1; k++) put(8'h78);
        wait_idle(low, nb);
        check_cursor("col97");
        put(8'h43);
        wait_idle(low, nb);
        put(8'h43);
        wait_idle(low, nb);
        check_cursor("last_col");

        put(8'h0A);
        put(8'h44);
        wait_idle(low, nb);
        check_cursor("held_byte");
        check("held_rd_drain", 32'(sb_rd.size()), 32'd0);

        put(8'h0A);
        repeat (40) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        sb_wr.delete();
        sb_rd.delete();
        mcol = 0;
        mrow = 0;
        @(negedge clk);
        rst = 1'b0;
        put(8'h45);
        wait_idle(low, nb);
        check_cursor("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
